// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-cache <-> main-memory interface: line geometry,
// channel state encodings and a line word-extract helper.
package mem_if_pkg;

    localparam int unsigned LINE_BITS      = 512;
    localparam int unsigned WORD_BITS      = 32;
    localparam int unsigned WORDS_PER_LINE = 16;
    localparam int unsigned OFFSET_BITS    = 6;

    // Read channel: idle, counting down latency, line valid on the outputs
    typedef enum logic [1:0] {
        RIdle,
        RWait,
        RValid
    } rd_state_e;

    // Write channel: idle, counting down latency, last write committed
    typedef enum logic [1:0] {
        WIdle,
        WBusy,
        WDone
    } wr_state_e;

    // Word idx of a line; word 0 sits in the least significant bits
    function automatic logic [WORD_BITS-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                       input int unsigned idx);
        return line[idx*WORD_BITS +: WORD_BITS];
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter used to time one memory channel: load a start value, count down to
// zero and hold there, flag zero.
module mem_latency_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Load has priority over decrement; the count saturates at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Zero flag straight from the register
    always_comb begin
        zero_o = (count_q == '0);
    end

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder for the data cache: serves 512-bit line reads and 32-bit word
// writes from a word-addressed backing store, each channel with its own fixed latency.
// The read and write channels are independent FSMs sharing one storage array.
module main_memory_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 16,
    parameter int unsigned READ_LATENCY   = 8,
    parameter int unsigned WRITE_LATENCY  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          memoryReadAddr,
    output logic [LINE_BITS-1:0] memoryReadData,
    output logic                 memoryReadEnable,
    input  logic                 memoryWritePulse,
    input  logic [31:0]          memoryWriteAddr,
    input  logic [31:0]          memoryWriteData,
    output logic                 memoryWriteDone
);

    localparam int unsigned MaxLatency  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                        : WRITE_LATENCY;
    localparam int unsigned CntWidth    = $clog2(MaxLatency) + 1;
    localparam int unsigned WordSelBits = $clog2(WORDS_PER_LINE);
    localparam int unsigned Depth       = 1 << MEM_ADDR_WIDTH;

    // Backing store; deliberately never cleared by reset
    logic [WORD_BITS-1:0] mem [Depth];

    // Read channel state
    rd_state_e            rd_state_q, rd_state_d;
    logic [31:0]          rd_addr_q, rd_addr_d;
    logic [LINE_BITS-1:0] rd_data_q, rd_data_d;
    logic                 rd_en_q, rd_en_d;
    logic                 rd_load, rd_dec, rd_zero;
    logic                 line_match, line_mismatch;
    logic [MEM_ADDR_WIDTH-5:0] rd_line_idx;
    logic [LINE_BITS-1:0] line_assembled;
    logic                 refresh_hit;

    // Write channel state
    wr_state_e                 wr_state_q, wr_state_d;
    logic [MEM_ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [WORD_BITS-1:0]      wr_data_q, wr_data_d;
    logic                      wr_done_q, wr_done_d;
    logic                      wr_load, wr_dec, wr_zero;
    logic                      wr_accept, wr_commit;

    // Address bits that alias away or select bytes within a word/line
    logic unused_addr_bits;
    assign unused_addr_bits = ^{memoryReadAddr[OFFSET_BITS-1:0], rd_addr_q[OFFSET_BITS-1:0],
                                memoryWriteAddr[31:MEM_ADDR_WIDTH+2], memoryWriteAddr[1:0]};

    assign rd_line_idx = rd_addr_q[MEM_ADDR_WIDTH+1:OFFSET_BITS];

    mem_latency_counter #(
        .Width (CntWidth)
    ) u_rd_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (rd_load),
        .load_value_i (CntWidth'(READ_LATENCY - 1)),
        .dec_i        (rd_dec),
        .zero_o       (rd_zero)
    );

    mem_latency_counter #(
        .Width (CntWidth)
    ) u_wr_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (wr_load),
        .load_value_i (CntWidth'(WRITE_LATENCY - 1)),
        .dec_i        (wr_dec),
        .zero_o       (wr_zero)
    );

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------

    // Accept and commit strobes shared by the write FSM, storage and read bypass
    always_comb begin
        wr_accept = memoryWritePulse && (wr_state_q != WBusy);
        wr_commit = (wr_state_q == WBusy) && wr_zero;
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WIdle;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    // Write FSM next state; pulses while busy are dropped
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WIdle, WDone: if (wr_accept) wr_state_d = WBusy;
            WBusy:        if (wr_zero)   wr_state_d = WDone;
            default:      wr_state_d = WIdle;
        endcase
    end

    // Write FSM outputs: latch request, drive counter, track done
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        wr_done_d = wr_done_q;
        wr_load   = wr_accept;
        wr_dec    = (wr_state_q == WBusy) && !wr_zero;
        if (wr_accept) begin
            wr_idx_d  = memoryWriteAddr[MEM_ADDR_WIDTH+1:2];
            wr_data_d = memoryWriteData;
            wr_done_d = 1'b0;
        end else if (wr_commit) begin
            wr_done_d = 1'b1;
        end
    end

    // Write channel datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            wr_done_q <= 1'b0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            wr_done_q <= wr_done_d;
        end
    end

    // Storage write; commit only happens out of reset since the FSM sits in WIdle
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[wr_idx_q] <= wr_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------

    // Line compare; an unknown compare result falls into the else and restarts the read
    always_comb begin
        line_match = (memoryReadAddr[31:OFFSET_BITS] == rd_addr_q[31:OFFSET_BITS]);
        if (line_match) begin
            line_mismatch = 1'b0;
        end else begin
            line_mismatch = 1'b1;
        end
    end

    // Gather the latched line, forwarding a same-edge commit so the line is never stale
    always_comb begin
        line_assembled = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (wr_commit && (wr_idx_q == {rd_line_idx, WordSelBits'(i)})) begin
                line_assembled[i*WORD_BITS +: WORD_BITS] = wr_data_q;
            end else begin
                line_assembled[i*WORD_BITS +: WORD_BITS] = mem[{rd_line_idx, WordSelBits'(i)}];
            end
        end
    end

    // A commit landing inside the line currently presented to the cache
    always_comb begin
        refresh_hit = wr_commit && (wr_idx_q[MEM_ADDR_WIDTH-1:WordSelBits] == rd_line_idx);
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RIdle;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    // Read FSM next state; a new line address restarts from any state
    always_comb begin
        rd_state_d = rd_state_q;
        if (line_mismatch) begin
            rd_state_d = RWait;
        end else begin
            case (rd_state_q)
                RIdle:   rd_state_d = RIdle;
                RWait:   if (rd_zero) rd_state_d = RValid;
                RValid:  rd_state_d = RValid;
                default: rd_state_d = RIdle;
            endcase
        end
    end

    // Read FSM outputs: latch address, drive counter, load or refresh line data
    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        rd_en_d   = rd_en_q;
        rd_load   = line_mismatch;
        rd_dec    = 1'b0;
        if (line_mismatch) begin
            rd_addr_d = memoryReadAddr;
            rd_en_d   = 1'b0;
        end else begin
            case (rd_state_q)
                RWait: begin
                    if (rd_zero) begin
                        rd_data_d = line_assembled;
                        rd_en_d   = 1'b1;
                    end else begin
                        rd_dec = 1'b1;
                    end
                end
                RValid: begin
                    if (refresh_hit) begin
                        rd_data_d[32'(wr_idx_q[WordSelBits-1:0])*WORD_BITS +: WORD_BITS] =
                            wr_data_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read channel datapath registers; all-ones address forces a fresh read after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= 32'hFFFF_FFFF;
            rd_data_q <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign memoryReadData   = rd_data_q;
    assign memoryReadEnable = rd_en_q;
    assign memoryWriteDone  = wr_done_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: a word-level memory model plus
// queues of expected latencies and lines, filled when stimulus is driven and
// drained when the responder answers.
module tb_main_memory_responder;
    import mem_if_pkg::*;

    localparam int unsigned MAW = 16;
    localparam int unsigned RL  = 8;
    localparam int unsigned WL  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [31:0]    memoryReadAddr = 32'hFFFF_FFC0;
    logic [511:0]   memoryReadData;
    logic           memoryReadEnable;
    logic           memoryWritePulse = 1'b0;
    logic [31:0]    memoryWriteAddr = '0;
    logic [31:0]    memoryWriteData = '0;
    logic           memoryWriteDone;

    int vectors = 0;
    int miscompares = 0;

    int           exp_lat_q[$];
    logic [511:0] exp_line_q[$];
    logic [31:0]  model [int unsigned];

    main_memory_responder #(
        .MEM_ADDR_WIDTH (MAW),
        .READ_LATENCY   (RL),
        .WRITE_LATENCY  (WL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .memoryReadAddr   (memoryReadAddr),
        .memoryReadData   (memoryReadData),
        .memoryReadEnable (memoryReadEnable),
        .memoryWritePulse (memoryWritePulse),
        .memoryWriteAddr  (memoryWriteAddr),
        .memoryWriteData  (memoryWriteData),
        .memoryWriteDone  (memoryWriteDone)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] model_line(input logic [31:0] addr);
        logic [511:0] l;
        int unsigned  base;
        l = '0;
        base = 32'(addr[MAW+1:6]) << 4;
        for (int i = 0; i < 16; i++) begin
            if (model.exists(base + 32'(i))) l[i*32 +: 32] = model[base + 32'(i)];
        end
        return l;
    endfunction

    task automatic wait_enable(input int budget, output int cycles);
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (memoryReadEnable === 1'b1) begin
                cycles = n;
                return;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (memoryWriteDone === 1'b1) begin
                cycles = n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (memoryReadEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_enable: got %b expected 0", memoryReadEnable);
        end
        vectors++;
        if (memoryReadData !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", memoryReadData);
        end
        vectors++;
        if (memoryWriteDone !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b expected 0", memoryWriteDone);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Fill words 16..47 (lines 0x40 and 0x80) through the write port
    task automatic test_preload();
        int c;
        int el;
        logic [31:0] a, d;
        for (int i = 0; i < 32; i++) begin
            a = 32'h40 + 32'(4 * i);
            d = (i < 16) ? (32'h100 + 32'(i)) : (32'h200 + 32'(i - 16));
            memoryWritePulse = 1'b1;
            memoryWriteAddr = a;
            memoryWriteData = d;
            model[32'(a[MAW+1:2])] = d;
            exp_lat_q.push_back(WL);
            tick();
            memoryWritePulse = 1'b0;
            vectors++;
            if (memoryWriteDone !== 1'b0) begin
                miscompares++;
                $display("FAIL preload_done_clear[%0d]: got %b expected 0", i, memoryWriteDone);
            end
            wait_done(4 * WL, c);
            el = exp_lat_q.pop_front();
            vectors++;
            if (c !== el) begin
                miscompares++;
                $display("FAIL preload_latency[%0d]: got %0d expected %0d", i, c, el);
            end
        end
    endtask

    task automatic test_read_latency();
        int c;
        int el;
        logic [511:0] line;
        memoryReadAddr = 32'h40;
        exp_lat_q.push_back(RL);
        exp_line_q.push_back(model_line(32'h40));
        tick();
        vectors++;
        if (memoryReadEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL read_start_enable: got %b expected 0", memoryReadEnable);
        end
        wait_enable(3 * RL, c);
        el = exp_lat_q.pop_front();
        line = exp_line_q.pop_front();
        vectors++;
        if (c !== el) begin
            miscompares++;
            $display("FAIL read_latency: got %0d expected %0d", c, el);
        end
        vectors++;
        if (memoryReadData !== line) begin
            miscompares++;
            $display("FAIL read_line40: got %h expected %h", memoryReadData, line);
        end
        vectors++;
        if (line_word(memoryReadData, 5) !== 32'h105) begin
            miscompares++;
            $display("FAIL read_word5: got %h expected %h", line_word(memoryReadData, 5),
                     32'h105);
        end
    endtask

    task automatic test_offset_change();
        int c;
        int el;
        logic [511:0] line;
        memoryReadAddr = 32'h7C;
        exp_line_q.push_back(model_line(32'h40));
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (memoryReadEnable !== 1'b1) begin
                miscompares++;
                $display("FAIL offset_enable[%0d]: got %b expected 1", i, memoryReadEnable);
            end
        end
        line = exp_line_q.pop_front();
        vectors++;
        if (memoryReadData !== line) begin
            miscompares++;
            $display("FAIL offset_data: got %h expected %h", memoryReadData, line);
        end
        memoryReadAddr = 32'h80;
        exp_lat_q.push_back(RL);
        exp_line_q.push_back(model_line(32'h80));
        tick();
        vectors++;
        if (memoryReadEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL newline_drop: got %b expected 0", memoryReadEnable);
        end
        wait_enable(3 * RL, c);
        el = exp_lat_q.pop_front();
        line = exp_line_q.pop_front();
        vectors++;
        if (c !== el) begin
            miscompares++;
            $display("FAIL newline_latency: got %0d expected %0d", c, el);
        end
        vectors++;
        if (memoryReadData !== line) begin
            miscompares++;
            $display("FAIL newline_data: got %h expected %h", memoryReadData, line);
        end
    endtask

    task automatic test_write_refresh();
        int c;
        int el;
        logic [511:0] line;
        memoryReadAddr = 32'h40;
        exp_lat_q.push_back(RL);
        tick();
        wait_enable(3 * RL, c);
        el = exp_lat_q.pop_front();
        vectors++;
        if (c !== el) begin
            miscompares++;
            $display("FAIL refresh_setup_latency: got %0d expected %0d", c, el);
        end
        memoryWritePulse = 1'b1;
        memoryWriteAddr = 32'h48;
        memoryWriteData = 32'hDEAD_BEEF;
        model[18] = 32'hDEAD_BEEF;
        exp_lat_q.push_back(WL);
        exp_line_q.push_back(model_line(32'h40));
        tick();
        memoryWritePulse = 1'b0;
        wait_done(4 * WL, c);
        el = exp_lat_q.pop_front();
        line = exp_line_q.pop_front();
        vectors++;
        if (c !== el) begin
            miscompares++;
            $display("FAIL refresh_write_latency: got %0d expected %0d", c, el);
        end
        vectors++;
        if (line_word(memoryReadData, 2) !== 32'hDEAD_BEEF || memoryReadEnable !== 1'b1) begin
            miscompares++;
            $display("FAIL refresh_word2: got %h en %b expected deadbeef en 1",
                     line_word(memoryReadData, 2), memoryReadEnable);
        end
        vectors++;
        if (memoryReadData !== line) begin
            miscompares++;
            $display("FAIL refresh_line: got %h expected %h", memoryReadData, line);
        end
    endtask

    task automatic test_busy_drop();
        int c;
        int el;
        int drops;
        logic [511:0] line;
        memoryWritePulse = 1'b1;
        memoryWriteAddr = 32'h4C;
        memoryWriteData = 32'h1111_1111;
        model[19] = 32'h1111_1111;
        // Two cycles are spent before waiting starts, so done is WL-2 cycles away
        exp_lat_q.push_back(WL - 2);
        exp_line_q.push_back(model_line(32'h40));
        tick();
        memoryWritePulse = 1'b0;
        tick();
        memoryWritePulse = 1'b1;
        memoryWriteAddr = 32'h50;
        memoryWriteData = 32'h2222_2222;
        tick();
        memoryWritePulse = 1'b0;
        wait_done(4 * WL, c);
        el = exp_lat_q.pop_front();
        line = exp_line_q.pop_front();
        vectors++;
        if (c !== el) begin
            miscompares++;
            $display("FAIL busy_latency: got %0d expected %0d", c, el);
        end
        vectors++;
        if (memoryReadData !== line) begin
            miscompares++;
            $display("FAIL busy_line: got %h expected %h", memoryReadData, line);
        end
        vectors++;
        if (line_word(memoryReadData, 4) !== 32'h104) begin
            miscompares++;
            $display("FAIL busy_dropped_word: got %h expected %h", line_word(memoryReadData, 4),
                     32'h104);
        end
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (memoryWriteDone !== 1'b1) drops++;
        end
        vectors++;
        if (drops !== 0) begin
            miscompares++;
            $display("FAIL busy_done_held: got %0d low cycles expected 0", drops);
        end
    endtask

    // Commit lands on the same edge the read of line 0x80 assembles
    task automatic test_write_first();
        int el_r, el_w;
        logic [511:0] line;
        memoryReadAddr = 32'h80;
        model[33] = 32'hCAFE_F00D;
        exp_lat_q.push_back(RL);
        exp_line_q.push_back(model_line(32'h80));
        tick();
        repeat (RL - WL - 1) tick();
        memoryWritePulse = 1'b1;
        memoryWriteAddr = 32'h84;
        memoryWriteData = 32'hCAFE_F00D;
        exp_lat_q.push_back(WL);
        tick();
        memoryWritePulse = 1'b0;
        repeat (WL - 1) tick();
        vectors++;
        if (memoryReadEnable !== 1'b0 || memoryWriteDone !== 1'b0) begin
            miscompares++;
            $display("FAIL wfirst_early: got en %b done %b expected 0 0", memoryReadEnable,
                     memoryWriteDone);
        end
        tick();
        el_r = exp_lat_q.pop_front();
        el_w = exp_lat_q.pop_front();
        line = exp_line_q.pop_front();
        vectors++;
        if (memoryReadEnable !== 1'b1 || el_r !== int'(RL)) begin
            miscompares++;
            $display("FAIL wfirst_enable: got %b at %0d expected 1 at %0d", memoryReadEnable,
                     RL, el_r);
        end
        vectors++;
        if (memoryWriteDone !== 1'b1 || el_w !== int'(WL)) begin
            miscompares++;
            $display("FAIL wfirst_done: got %b at %0d expected 1 at %0d", memoryWriteDone,
                     WL, el_w);
        end
        vectors++;
        if (line_word(memoryReadData, 1) !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL wfirst_word1: got %h expected cafef00d",
                     line_word(memoryReadData, 1));
        end
        vectors++;
        if (memoryReadData !== line) begin
            miscompares++;
            $display("FAIL wfirst_line: got %h expected %h", memoryReadData, line);
        end
    endtask

    task automatic test_reset_mid_op();
        int c;
        int el;
        logic [511:0] line;
        memoryReadAddr = 32'h40;
        tick();
        repeat (2) tick();
        memoryWritePulse = 1'b1;
        memoryWriteAddr = 32'h40;
        memoryWriteData = 32'hBAD0_BAD0;
        tick();
        memoryWritePulse = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (memoryReadEnable !== 1'b0 || memoryReadData !== '0 || memoryWriteDone !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset_outputs: got en %b done %b data %h expected all 0",
                     memoryReadEnable, memoryWriteDone, memoryReadData);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        exp_lat_q.push_back(RL);
        exp_line_q.push_back(model_line(32'h40));
        tick();
        vectors++;
        if (memoryReadEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_restart_enable: got %b expected 0", memoryReadEnable);
        end
        wait_enable(3 * RL, c);
        el = exp_lat_q.pop_front();
        line = exp_line_q.pop_front();
        vectors++;
        if (c !== el) begin
            miscompares++;
            $display("FAIL midop_latency: got %0d expected %0d", c, el);
        end
        vectors++;
        if (memoryReadData !== line) begin
            miscompares++;
            $display("FAIL midop_line: got %h expected %h", memoryReadData, line);
        end
        vectors++;
        if (line_word(memoryReadData, 0) !== 32'h100 || memoryWriteDone !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_write_lost: got word0 %h done %b expected 00000100 0",
                     line_word(memoryReadData, 0), memoryWriteDone);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_read_latency();
        test_offset_change();
        test_write_refresh();
        test_busy_drop();
        test_write_first();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Memory-side responder for the data cache's miss/write-through interface.
- Serves 512-bit cache-line reads and 32-bit word writes from a word-addressed backing store, with parameterised latency.
- Sits between the data cache and the simulated main memory. Replaces ad-hoc testbench memory models.
- Read and write channels are independent FSMs over one shared storage array.

Parameters:
- MEM_ADDR_WIDTH, 16: log2 of the backing-store depth in 32-bit words. Address bits above MEM_ADDR_WIDTH+1 are ignored, so the address space aliases.
- READ_LATENCY, 8: cycles from accepting a line address to asserting memoryReadEnable. Must be >= 1.
- WRITE_LATENCY, 4: cycles from accepting a write pulse to committing the word and asserting memoryWriteDone. Must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- memoryReadAddr  in  32  line-read byte address; bits [5:0] are ignored.
- memoryReadData  out  512  line data; word i sits in bits [32i+31:32i], word i is at line base + 4i.
- memoryReadEnable  out  1  high while memoryReadData is valid for the current memoryReadAddr.
- memoryWritePulse  in  1  write request, sampled at posedge clk.
- memoryWriteAddr  in  32  write byte address; bits [1:0] are ignored.
- memoryWriteData  in  32  write word.
- memoryWriteDone  out  1  high once the last accepted write is committed.

Behaviour:
- Reset (async assert, sync release):
  - memoryReadEnable=0, memoryReadData=0, memoryWriteDone=0.
  - Both FSMs go to IDLE. The latched read address is set to 32'hFFFFFFFF.
  - Storage contents are NOT cleared.
  - Reset mid-read or mid-write abandons the operation. An uncommitted write is lost.
- Read FSM, states R_IDLE, R_WAIT, R_VALID:
  - Each cycle, the line address memoryReadAddr[31:6] is compared with the latched line address. An X-valued address counts as a mismatch.
  - On mismatch in any state: latch the new address, load counter = READ_LATENCY-1, drop memoryReadEnable, go to R_WAIT.
  - In R_WAIT with counter == 0: assemble 16 words from storage, drive memoryReadData, set memoryReadEnable=1, go to R_VALID. Otherwise decrement the counter.
  - With READ_LATENCY=1, memoryReadEnable rises on the cycle after the address changes.
  - R_VALID holds data and enable while the line address is stable. Offset-only changes (bits [5:0]) do not restart the read.
  - A commit to a word inside the latched line while in R_VALID refreshes that word in memoryReadData on the same edge. The cache never sees stale data.
- Write FSM, states W_IDLE, W_BUSY, W_DONE:
  - W_IDLE or W_DONE with memoryWritePulse=1: latch address and data, clear memoryWriteDone, load counter = WRITE_LATENCY-1, go to W_BUSY.
  - W_BUSY with counter == 0: write mem[addr[MEM_ADDR_WIDTH+1:2]], set memoryWriteDone=1, go to W_DONE. Otherwise decrement the counter.
  - memoryWriteDone stays high in W_DONE until the next accepted pulse.
  - Pulses arriving in W_BUSY are ignored (dropped). Initiators must wait for done.
- Simultaneous events:
  - A write commit and a read-data assembly on the same edge are write-first: the assembled line contains the new word.
  - A read address change and a write pulse on the same edge are both accepted.
- Width rules:
  - Line base word index = {addr[MEM_ADDR_WIDTH+1:6], 4'b0000}.
  - Counters are $clog2(max latency)+1 bits wide.

Decomposition:
- Shared package mem_if_pkg holds:
  - LINE_BITS=512, WORD_BITS=32, WORDS_PER_LINE=16, OFFSET_BITS=6.
  - The read and write state enum typedefs.
  - The line-extract helper, reused by the data cache.
- One natural sub-module, mem_latency_counter: load, decrement, zero flag. Instantiated once per channel.
- Storage and both FSMs live in the top module.

Test Plan:
- Preload mem[16..31] = 32'h100+i. Set memoryReadAddr=32'h40 after reset, READ_LATENCY=8 -> memoryReadEnable rises exactly 8 cycles later, memoryReadData word i = 32'h100+i.
- In R_VALID, change the address from 32'h40 to 32'h7C -> memoryReadEnable stays 1 and the data is unchanged. Then change it to 32'h80 -> memoryReadEnable drops the next cycle and re-rises after 8 cycles with the line at word 32.
- Pulse a write with addr=32'h48, data=32'hDEADBEEF while R_VALID on line 32'h40, WRITE_LATENCY=4 -> memoryWriteDone=1 after 4 cycles, and memoryReadData word 2 = 32'hDEADBEEF on the same edge.
- Issue a second pulse 2 cycles after the first (W_BUSY) -> it is ignored, only the first word is committed, memoryWriteDone asserts once.
- Commit a write to 32'h84 on the same edge the read of line 32'h80 completes -> memoryReadEnable=1 with word 1 equal to the new data.
- Assert rst_n=0 mid-R_WAIT and mid-W_BUSY -> outputs are 0 immediately; after release the pending write is absent from storage, and re-presenting the same address restarts the full READ_LATENCY.
